// File: rtl/ex_wb_bypass_stage.sv
// Execute/writeback stage: ID/EX and EX/WB registers with RAW hazard resolution on rs1/rs2.
// Define FORWARDING_EN for EX/WB bypass muxes; leave it undefined to stall instead.
module ex_wb_bypass_stage #(
    parameter int unsigned N      = 32,
    parameter int unsigned AWIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [AWIDTH-1:0] id_rs1_addr,
    input  logic [AWIDTH-1:0] id_rs2_addr,
    input  logic [N-1:0]      id_rs1_data,
    input  logic [N-1:0]      id_rs2_data,
    input  logic [AWIDTH-1:0] id_rd_addr,
    input  logic              id_rd_we,
    input  logic [3:0]        id_alu_sel,
    input  logic              flush,
    output logic [N-1:0]      ex_a,
    output logic [N-1:0]      ex_b,
    output logic [3:0]        ex_alu_sel,
    input  logic [N-1:0]      ex_alu_res,
    output logic              wb_we,
    output logic [AWIDTH-1:0] wb_addr,
    output logic [N-1:0]      wb_data,
    output logic [31:0]       retired_cnt
);

    logic              ex_valid_q, ex_valid_d;
    logic [N-1:0]      ex_a_q, ex_a_d;
    logic [N-1:0]      ex_b_q, ex_b_d;
    logic [3:0]        ex_alu_sel_q, ex_alu_sel_d;
    logic [AWIDTH-1:0] ex_rd_addr_q, ex_rd_addr_d;
    logic              ex_rd_we_q, ex_rd_we_d;

    logic              wb_valid_q, wb_valid_d;
    logic [AWIDTH-1:0] wb_rd_addr_q, wb_rd_addr_d;
    logic              wb_rd_we_q, wb_rd_we_d;
    logic [N-1:0]      wb_data_q, wb_data_d;

    logic [31:0]       retired_cnt_q, retired_cnt_d;

    logic              ex_hit1, ex_hit2, wb_hit1, wb_hit2;
    logic [N-1:0]      op_a, op_b;
    logic              accept;

    always_comb begin
        ex_hit1 = ex_valid_q & ex_rd_we_q & (id_rs1_addr == ex_rd_addr_q) & (id_rs1_addr != '0);
        ex_hit2 = ex_valid_q & ex_rd_we_q & (id_rs2_addr == ex_rd_addr_q) & (id_rs2_addr != '0);
        wb_hit1 = wb_valid_q & wb_rd_we_q & (id_rs1_addr == wb_rd_addr_q) & (id_rs1_addr != '0);
        wb_hit2 = wb_valid_q & wb_rd_we_q & (id_rs2_addr == wb_rd_addr_q) & (id_rs2_addr != '0);
    end

`ifdef FORWARDING_EN
    // Youngest producer wins; WB bypass covers the same-cycle regfile write/read collision.
    always_comb begin
        op_a = id_rs1_data;
        if (id_rs1_addr == '0) begin
            op_a = '0;
        end else if (ex_hit1) begin
            op_a = ex_alu_res;
        end else if (wb_hit1) begin
            op_a = wb_data_q;
        end

        op_b = id_rs2_data;
        if (id_rs2_addr == '0) begin
            op_b = '0;
        end else if (ex_hit2) begin
            op_b = ex_alu_res;
        end else if (wb_hit2) begin
            op_b = wb_data_q;
        end

        id_ready = 1'b1;
    end
`else
    always_comb begin
        op_a     = (id_rs1_addr == '0) ? '0 : id_rs1_data;
        op_b     = (id_rs2_addr == '0) ? '0 : id_rs2_data;
        id_ready = ~(id_valid & (ex_hit1 | ex_hit2 | wb_hit1 | wb_hit2));
    end
`endif

    always_comb begin
        accept = id_valid & id_ready & ~flush;

        ex_valid_d   = accept;
        ex_a_d       = ex_a_q;
        ex_b_d       = ex_b_q;
        ex_alu_sel_d = ex_alu_sel_q;
        ex_rd_addr_d = ex_rd_addr_q;
        ex_rd_we_d   = ex_rd_we_q;
        if (accept) begin
            ex_a_d       = op_a;
            ex_b_d       = op_b;
            ex_alu_sel_d = id_alu_sel;
            ex_rd_addr_d = id_rd_addr;
            ex_rd_we_d   = id_rd_we;
        end

        wb_valid_d   = ex_valid_q;
        wb_rd_addr_d = ex_rd_addr_q;
        wb_rd_we_d   = ex_rd_we_q;
        wb_data_d    = ex_alu_res;

        retired_cnt_d = retired_cnt_q + 32'(wb_valid_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q    <= 1'b0;
            ex_a_q        <= '0;
            ex_b_q        <= '0;
            ex_alu_sel_q  <= '0;
            ex_rd_addr_q  <= '0;
            ex_rd_we_q    <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_rd_addr_q  <= '0;
            wb_rd_we_q    <= 1'b0;
            wb_data_q     <= '0;
            retired_cnt_q <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_a_q        <= ex_a_d;
            ex_b_q        <= ex_b_d;
            ex_alu_sel_q  <= ex_alu_sel_d;
            ex_rd_addr_q  <= ex_rd_addr_d;
            ex_rd_we_q    <= ex_rd_we_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_addr_q  <= wb_rd_addr_d;
            wb_rd_we_q    <= wb_rd_we_d;
            wb_data_q     <= wb_data_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    // Gated by rst so an instruction sitting in WB is dropped in the reset cycle.
    assign wb_we       = wb_valid_q & wb_rd_we_q & (wb_rd_addr_q != '0) & ~rst;
    assign wb_addr     = wb_rd_addr_q;
    assign wb_data     = wb_data_q;
    assign ex_a        = ex_a_q;
    assign ex_b        = ex_b_q;
    assign ex_alu_sel  = ex_alu_sel_q;
    assign retired_cnt = retired_cnt_q;

endmodule

// File: tb/tb_ex_wb_bypass_stage.sv
// Bench for ex_wb_bypass_stage: regfile + ALU environment, vector table, scoreboard queues.
module tb_ex_wb_bypass_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic        id_ready;
    logic [4:0]  id_rs1_addr = '0, id_rs2_addr = '0, id_rd_addr = '0;
    logic [31:0] id_rs1_data, id_rs2_data;
    logic        id_rd_we = 1'b0;
    logic [3:0]  id_alu_sel = '0;
    logic        flush = 1'b0;
    logic [31:0] ex_a, ex_b, ex_alu_res, wb_data, retired_cnt;
    logic [3:0]  ex_alu_sel;
    logic        wb_we;
    logic [4:0]  wb_addr;

    ex_wb_bypass_stage #(.N(32), .AWIDTH(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we), .id_alu_sel(id_alu_sel),
        .flush(flush), .ex_a(ex_a), .ex_b(ex_b), .ex_alu_sel(ex_alu_sel),
        .ex_alu_res(ex_alu_res), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    // Environment: async-read regfile with a preload port, and the ALU.
    logic [31:0] rf [32];
    logic        pre_we = 1'b0;
    logic [4:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) rf[pre_addr] <= pre_data;
        else if (wb_we) rf[wb_addr] <= wb_data;
    end
    assign id_rs1_data = rf[id_rs1_addr];
    assign id_rs2_data = rf[id_rs2_addr];

    always_comb begin
        ex_alu_res = ex_a + ex_b;
        case (ex_alu_sel)
            4'd1: ex_alu_res = ex_a - ex_b;
            4'd2: ex_alu_res = ex_a & ex_b;
            4'd3: ex_alu_res = ex_a | ex_b;
            4'd4: ex_alu_res = ex_a ^ ex_b;
            default: ex_alu_res = ex_a + ex_b;
        endcase
    end

    typedef struct {
        logic [4:0]  rd, rs1, rs2;
        logic [3:0]  sel;
        bit          we, fl;
        logic [31:0] res;
        int          st_nf;
    } vec_t;
    typedef struct { int due; logic [31:0] a, b; logic [3:0] sel; } ex_exp_t;
    typedef struct { int due; bit we; logic [4:0] addr; logic [31:0] data; } wb_exp_t;

    ex_exp_t     ex_q [$];
    wb_exp_t     wb_q [$];
    logic [31:0] gold [32];
    vec_t        vecs [18];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          exp_ret = 0;
    bit          mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] pre_val(input int i);
        if (i == 0) return 32'hDEAD_BEEF;
        if (i == 1) return 32'd5;
        if (i == 2) return 32'd3;
        return 32'h1000 + 32'(i);
    endfunction

    always @(negedge clk) begin
        ex_exp_t e;
        wb_exp_t w;
        if (mon_en) begin
            if (rst) begin
                chk("wb_we_in_reset", {31'b0, wb_we}, 32'd0);
                ex_q.delete();
                wb_q.delete();
                exp_ret = 0;
            end else begin
                chk("retired_cnt", retired_cnt, 32'(exp_ret));
                if (ex_q.size() > 0 && ex_q[0].due == cyc) begin
                    e = ex_q.pop_front();
                    chk("ex_a", ex_a, e.a);
                    chk("ex_b", ex_b, e.b);
                    chk("ex_alu_sel", {28'b0, ex_alu_sel}, {28'b0, e.sel});
                end
                if (wb_q.size() > 0 && wb_q[0].due == cyc) begin
                    w = wb_q.pop_front();
                    exp_ret++;
                    chk("wb_we", {31'b0, wb_we}, {31'b0, w.we});
                    if (w.we) begin
                        chk("wb_addr", {27'b0, wb_addr}, {27'b0, w.addr});
                        chk("wb_data", wb_data, w.data);
                    end
                end else begin
                    chk("wb_we_idle", {31'b0, wb_we}, 32'd0);
                end
            end
        end
    end

    task automatic issue(input vec_t v);
        int      st;
        int      exp_st;
        ex_exp_t e;
        wb_exp_t w;
        id_valid    = 1'b1;
        id_rs1_addr = v.rs1;
        id_rs2_addr = v.rs2;
        id_rd_addr  = v.rd;
        id_rd_we    = v.we;
        id_alu_sel  = v.sel;
        flush       = v.fl;
        st          = 0;
`ifdef FORWARDING_EN
        exp_st = 0;
`else
        exp_st = v.st_nf;
`endif
        @(negedge clk);
        while (!id_ready && st < 8) begin
            st++;
            @(negedge clk);
        end
        chk("stall_cycles", 32'(st), 32'(exp_st));
        if (id_ready && !v.fl) begin
            e.due = cyc + 1;
            e.a   = (v.rs1 == 0) ? 32'd0 : gold[v.rs1];
            e.b   = (v.rs2 == 0) ? 32'd0 : gold[v.rs2];
            e.sel = v.sel;
            ex_q.push_back(e);
            w.due  = cyc + 2;
            w.we   = v.we && (v.rd != 0);
            w.addr = v.rd;
            w.data = v.res;
            wb_q.push_back(w);
            if (w.we) gold[v.rd] = v.res;
        end
        @(posedge clk);
        #1;
        id_valid = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        logic [31:0] save18, save21;
        //          rd     rs1    rs2    sel   we    fl    result          stalls (no fwd)
        vecs[0]  = '{5'd4,  5'd1,  5'd2,  4'd0, 1'b1, 1'b0, 32'd8,          0};
        vecs[1]  = '{5'd5,  5'd4,  5'd1,  4'd0, 1'b1, 1'b0, 32'd13,         2};
        vecs[2]  = '{5'd7,  5'd1,  5'd1,  4'd0, 1'b1, 1'b0, 32'd10,         0};
        vecs[3]  = '{5'd8,  5'd5,  5'd2,  4'd1, 1'b1, 1'b0, 32'd10,         1};
        vecs[4]  = '{5'd0,  5'd1,  5'd2,  4'd3, 1'b1, 1'b0, 32'd7,          0};
        vecs[5]  = '{5'd9,  5'd0,  5'd2,  4'd0, 1'b1, 1'b0, 32'd3,          0};
        vecs[6]  = '{5'd10, 5'd9,  5'd5,  4'd2, 1'b1, 1'b0, 32'd1,          2};
        vecs[7]  = '{5'd11, 5'd10, 5'd9,  4'd4, 1'b1, 1'b0, 32'd2,          2};
        vecs[8]  = '{5'd12, 5'd1,  5'd2,  4'd0, 1'b0, 1'b0, 32'd8,          0};
        vecs[9]  = '{5'd13, 5'd12, 5'd0,  4'd0, 1'b1, 1'b0, 32'h0000_100C,  0};
        vecs[10] = '{5'd14, 5'd1,  5'd1,  4'd0, 1'b1, 1'b0, 32'd10,         0};
        vecs[11] = '{5'd14, 5'd14, 5'd2,  4'd0, 1'b1, 1'b0, 32'd13,         2};
        vecs[12] = '{5'd15, 5'd14, 5'd0,  4'd0, 1'b1, 1'b0, 32'd13,         2};
        vecs[13] = '{5'd16, 5'd1,  5'd2,  4'd0, 1'b1, 1'b1, 32'd8,          0};
        vecs[14] = '{5'd17, 5'd16, 5'd0,  4'd0, 1'b1, 1'b0, 32'h0000_1010,  0};
        vecs[15] = '{5'd20, 5'd3,  5'd6,  4'd1, 1'b1, 1'b0, 32'hFFFF_FFFD,  0};
        // Reset sequence: A and B are dropped by rst, C reads the untouched x18.
        vecs[16] = '{5'd18, 5'd1,  5'd2,  4'd0, 1'b1, 1'b0, 32'd8,          0};
        vecs[17] = '{5'd21, 5'd1,  5'd1,  4'd0, 1'b1, 1'b0, 32'd10,         0};

        pre_we = 1'b1;
        for (int i = 0; i < 32; i++) begin
            pre_addr = 5'(i);
            pre_data = pre_val(i);
            gold[i]  = (i == 0) ? 32'd0 : pre_val(i);
            @(posedge clk);
            #1;
        end
        pre_we = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        @(negedge clk);
        chk("rst_ex_a", ex_a, 32'd0);
        chk("rst_ex_b", ex_b, 32'd0);
        chk("rst_ex_alu_sel", {28'b0, ex_alu_sel}, 32'd0);
        chk("rst_wb_addr", {27'b0, wb_addr}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_id_ready", {31'b0, id_ready}, 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) issue(vecs[i]);

        save18 = gold[18];
        save21 = gold[21];
        issue(vecs[16]);
        issue(vecs[17]);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        gold[18] = save18;
        gold[21] = save21;
        @(negedge clk);
        chk("post_rst_wb_we", {31'b0, wb_we}, 32'd0);
        chk("post_rst_ex_a", ex_a, 32'd0);
        @(posedge clk);
        #1;
        issue('{5'd19, 5'd18, 5'd0, 4'd0, 1'b1, 1'b0, 32'h0000_1012, 0});

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(ex_q.size() + wb_q.size()), 32'd0);
        chk("final_retired_cnt", retired_cnt, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
